// File: rtl/gb_interconnect_pkg.sv
// GLITCBUS slot interconnect shared types and helpers.
// FSM encoding, default bad-data word and the alias slot lookup.
package gb_interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [31:0] BAD_DATA_DEFAULT = 32'hDEADBEEF;

  // Pick the bits-wide field of map at position slot.
  function automatic logic [7:0] slot_map(
    input int unsigned  slot,
    input logic [255:0] map,
    input int           bits
  );
    logic [255:0] sh;
    logic [7:0]   r;
    sh = map >> (slot * bits);
    r  = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < bits) r[i] = sh[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gb_timeout_counter.sv
// Slave acknowledge timeout counter.
// Cleared by load, counts while enabled, flags when it reaches the limit.
module gb_timeout_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             count_i,
  input  logic [WIDTH-1:0] limit_i,
`ifdef GB_INTERCONNECT_DEBUG_EN
  output logic [WIDTH-1:0] cnt_o,
`endif
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear on load, otherwise count up without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == limit_i);
`ifdef GB_INTERCONNECT_DEBUG_EN
  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/gb_slot_interconnect.sv
// GLITCBUS local-side interconnect: registered slot select, alias map,
// ack handshake with timeout, bus errors. Option: GB_INTERCONNECT_DEBUG_EN.
module gb_slot_interconnect
  import gb_interconnect_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int SLOT_LSB   = 4,
  parameter int SLOT_BITS  = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter logic [SLOT_BITS*(2**SLOT_BITS)-1:0] ALIAS_MAP =
    {3'd3, 3'd2, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
  parameter int TIMEOUT    = 15,
  parameter logic [DATA_WIDTH-1:0] BAD_DATA =
    DATA_WIDTH'(BAD_DATA_DEFAULT)
) (
  input  logic                            user_clk_i,
  input  logic                            user_rst_i,
  input  logic [ADDR_WIDTH-1:0]           gb_adr_i,
  input  logic [DATA_WIDTH-1:0]           gb_dat_i,
  input  logic                            gb_wr_i,
  input  logic                            gb_rd_i,
  output logic [DATA_WIDTH-1:0]           gb_dat_o,
  output logic                            gb_ack_o,
  output logic [ADDR_WIDTH-1:0]           slv_adr_o,
  output logic [DATA_WIDTH-1:0]           slv_dat_o,
  output logic [NUM_SLOTS-1:0]            slv_sel_o,
  output logic                            slv_wr_o,
  output logic                            slv_rd_o,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] slv_dat_i,
  input  logic [NUM_SLOTS-1:0]            slv_ack_i,
`ifdef GB_INTERCONNECT_DEBUG_EN
  output logic [70:0]                     debug_o,
`endif
  output logic                            err_o,
  output logic [15:0]                     err_count_o
);

  localparam logic [255:0] MAP_EXT = 256'(ALIAS_MAP);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [NUM_SLOTS-1:0]  sel_q, sel_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  ack_q, ack_d;
  logic [3:0]            phys_q, phys_d;
  logic                  terr_q, terr_d;
  logic                  err_q, err_d;
  logic [15:0]           ecnt_q, ecnt_d;

  logic [7:0]            phys_w;
  logic                  strobe;
  logic                  slv_ack;
  logic [DATA_WIDTH-1:0] slv_rdat;
  logic                  cnt_load;
  logic                  cnt_en;
  logic                  expire;
  logic                  done_err;
  logic                  drop;
  logic [16:0]           ecnt_sum;

  assign strobe = gb_rd_i | gb_wr_i;
  assign phys_w = slot_map(32'(gb_adr_i[SLOT_LSB+:SLOT_BITS]),
                           MAP_EXT, SLOT_BITS);

  // Route the selected slave's ack and read data.
  always_comb begin
    slv_ack  = 1'b0;
    slv_rdat = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (phys_q == 4'(i)) begin
        slv_ack  = slv_ack_i[i];
        slv_rdat = slv_dat_i[i*DATA_WIDTH+:DATA_WIDTH];
      end
    end
  end

`ifdef GB_INTERCONNECT_DEBUG_EN
  logic [7:0] tmo_cnt;
`endif

  gb_timeout_counter #(
    .WIDTH(8)
  ) u_tmo (
    .clk_i   (user_clk_i),
    .rst_i   (user_rst_i),
    .load_i  (cnt_load),
    .count_i (cnt_en),
    .limit_i (8'(TIMEOUT - 1)),
`ifdef GB_INTERCONNECT_DEBUG_EN
    .cnt_o   (tmo_cnt),
`endif
    .expire_o(expire)
  );

  // Transaction FSM next state and registered outputs.
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    rdat_d   = rdat_q;
    ack_d    = 1'b0;
    phys_d   = phys_q;
    terr_d   = terr_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    done_err = 1'b0;
    drop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          adr_d  = gb_adr_i;
          wdat_d = gb_dat_i;
          if ((phys_w >= 8'(NUM_SLOTS)) || (gb_rd_i && gb_wr_i)) begin
            state_d = ST_DONE;
            rdat_d  = BAD_DATA;
            terr_d  = 1'b1;
          end else begin
            state_d = ST_STROBE;
            phys_d  = phys_w[3:0];
            rd_d    = gb_rd_i;
            wr_d    = gb_wr_i;
            terr_d  = 1'b0;
            sel_d   = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (phys_w == 8'(i)) sel_d[i] = 1'b1;
            end
          end
        end
      end
      ST_STROBE: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (slv_ack) begin
          rdat_d  = slv_rdat;
          sel_d   = '0;
          state_d = ST_DONE;
        end else if (expire) begin
          rdat_d  = BAD_DATA;
          terr_d  = 1'b1;
          sel_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ack_d    = 1'b1;
        done_err = terr_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && strobe) drop = 1'b1;
  end

  // Sticky error flag and saturating error count.
  always_comb begin
    ecnt_sum = 17'(ecnt_q) + 17'(done_err) + 17'(drop);
    ecnt_d   = ecnt_sum[16] ? 16'hFFFF : ecnt_sum[15:0];
    err_d    = err_q | done_err | drop;
  end

  // State and output registers.
  always_ff @(posedge user_clk_i) begin
    if (user_rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      phys_q  <= '0;
      terr_q  <= 1'b0;
      err_q   <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      phys_q  <= phys_d;
      terr_q  <= terr_d;
      err_q   <= err_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign gb_dat_o    = rdat_q;
  assign gb_ack_o    = ack_q;
  assign slv_adr_o   = adr_q;
  assign slv_dat_o   = wdat_q;
  assign slv_sel_o   = sel_q;
  assign slv_wr_o    = wr_q;
  assign slv_rd_o    = rd_q;
  assign err_o       = err_q;
  assign err_count_o = ecnt_q;

`ifdef GB_INTERCONNECT_DEBUG_EN
  assign debug_o = {state_q, phys_q, tmo_cnt, 16'(slv_ack_i),
                    gb_rd_i, gb_wr_i, ack_q, err_q,
                    32'(rdat_q), 5'd0};
`endif

endmodule

// File: tb/tb_gb_slot_interconnect.sv
// Directed bench for gb_slot_interconnect.
// Hand-computed expectations for reads, writes, timeout, errors, reset.
module tb_gb_slot_interconnect;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  gb_adr_i;
  logic [31:0]  gb_dat_i;
  logic         gb_wr_i;
  logic         gb_rd_i;
  logic [31:0]  gb_dat_o;
  logic         gb_ack_o;
  logic [15:0]  slv_adr_o;
  logic [31:0]  slv_dat_o;
  logic [7:0]   slv_sel_o;
  logic         slv_wr_o;
  logic         slv_rd_o;
  logic [255:0] slv_dat_i;
  logic [7:0]   slv_ack_i;
  logic         err_o;
  logic [15:0]  err_count_o;
`ifdef GB_INTERCONNECT_DEBUG_EN
  logic [70:0]  debug_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gb_slot_interconnect dut (
    .user_clk_i (clk),
    .user_rst_i (rst),
    .gb_adr_i   (gb_adr_i),
    .gb_dat_i   (gb_dat_i),
    .gb_wr_i    (gb_wr_i),
    .gb_rd_i    (gb_rd_i),
    .gb_dat_o   (gb_dat_o),
    .gb_ack_o   (gb_ack_o),
    .slv_adr_o  (slv_adr_o),
    .slv_dat_o  (slv_dat_o),
    .slv_sel_o  (slv_sel_o),
    .slv_wr_o   (slv_wr_o),
    .slv_rd_o   (slv_rd_o),
    .slv_dat_i  (slv_dat_i),
    .slv_ack_i  (slv_ack_i),
`ifdef GB_INTERCONNECT_DEBUG_EN
    .debug_o    (debug_o),
`endif
    .err_o      (err_o),
    .err_count_o(err_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one transaction at the current negedge and follow it to gb_ack_o.
  // ack_mask is driven for one cycle at negedge 2+k (k<0: never).
  task automatic xfer(input logic rd, input logic wr,
                      input logic [15:0] adr, input logic [31:0] wd,
                      input logic [7:0] ack_mask, input int k,
                      output int lat, output int nrd, output int nwr,
                      output logic [7:0] sel_s, output logic [31:0] wd_s);
    lat = -1; nrd = 0; nwr = 0; sel_s = '0; wd_s = '0;
    gb_rd_i = rd; gb_wr_i = wr; gb_adr_i = adr; gb_dat_i = wd;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      gb_rd_i = 1'b0; gb_wr_i = 1'b0;
      if (slv_rd_o || slv_wr_o) begin
        sel_s = slv_sel_o;
        wd_s  = slv_dat_o;
      end
      nrd += int'(slv_rd_o);
      nwr += int'(slv_wr_o);
      slv_ack_i = (k >= 0 && i == 2 + k) ? ack_mask : 8'h00;
      if (gb_ack_o) begin
        lat = i;
        break;
      end
    end
    slv_ack_i = '0;
  endtask

  int          lat, nrd, nwr, acks;
  logic [7:0]  sel_s;
  logic [31:0] wd_s;

  initial begin
    rst = 1'b1;
    gb_adr_i = '0; gb_dat_i = '0; gb_wr_i = 1'b0; gb_rd_i = 1'b0;
    slv_ack_i = '0;
    for (int i = 0; i < 8; i++) slv_dat_i[i*32+:32] = 32'hC0DE0000 + 32'(i);
    slv_dat_i[2*32+:32] = 32'h12345678;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_ack",  32'(gb_ack_o), 0);
    chk("rst_dat",  gb_dat_o, 0);
    chk("rst_sel",  32'(slv_sel_o), 0);
    chk("rst_rdwr", 32'({slv_rd_o, slv_wr_o}), 0);
    chk("rst_err",  32'(err_o), 0);
    chk("rst_ecnt", 32'(err_count_o), 0);

    // Read slot 2, slave acks in first WAIT cycle.
    xfer(1, 0, 16'h0020, 0, 8'h04, 0, lat, nrd, nwr, sel_s, wd_s);
    chk("rd2_lat",  32'(lat), 4);
    chk("rd2_dat",  gb_dat_o, 32'h12345678);
    chk("rd2_sel",  32'(sel_s), 32'h04);
    chk("rd2_nrd",  32'(nrd), 1);
    chk("rd2_err",  32'(err_o), 0);

    // Logical slot 6 aliases onto slave 2.
    xfer(1, 0, 16'h0060, 0, 8'h04, 0, lat, nrd, nwr, sel_s, wd_s);
    chk("rd6_sel",  32'(sel_s), 32'h04);
    chk("rd6_dat",  gb_dat_o, 32'h12345678);
    chk("rd6_lat",  32'(lat), 4);

    // Write slot 4.
    xfer(0, 1, 16'h0040, 32'hA5A5A5A5, 8'h10, 0, lat, nrd, nwr, sel_s, wd_s);
    chk("wr4_nwr",  32'(nwr), 1);
    chk("wr4_nrd",  32'(nrd), 0);
    chk("wr4_wdat", wd_s, 32'hA5A5A5A5);
    chk("wr4_sel",  32'(sel_s), 32'h10);
    chk("wr4_lat",  32'(lat), 4);
    chk("wr4_dat",  gb_dat_o, 32'hC0DE0004);

    // Slot 3 never acks; a stray ack from slave 2 is ignored.
    xfer(1, 0, 16'h0030, 0, 8'h04, 0, lat, nrd, nwr, sel_s, wd_s);
    chk("tmo_lat",  32'(lat), 18);
    chk("tmo_dat",  gb_dat_o, 32'hDEADBEEF);
    chk("tmo_err",  32'(err_o), 1);
    chk("tmo_ecnt", 32'(err_count_o), 1);

    // Ack in the last WAIT cycle beats the timeout.
    xfer(1, 0, 16'h0030, 0, 8'h08, 14, lat, nrd, nwr, sel_s, wd_s);
    chk("edge_lat",  32'(lat), 18);
    chk("edge_dat",  gb_dat_o, 32'hC0DE0003);
    chk("edge_ecnt", 32'(err_count_o), 1);

    // Read and write together: error, no slave strobe.
    xfer(1, 1, 16'h0020, 0, 8'h04, 0, lat, nrd, nwr, sel_s, wd_s);
    chk("both_lat",  32'(lat), 2);
    chk("both_strb", 32'(nrd + nwr), 0);
    chk("both_dat",  gb_dat_o, 32'hDEADBEEF);
    chk("both_ecnt", 32'(err_count_o), 2);

    // Reset while waiting on slave 3.
    gb_rd_i = 1'b1; gb_adr_i = 16'h0030;
    @(negedge clk);
    gb_rd_i = 1'b0;
    @(negedge clk);
    chk("mid_sel", 32'(slv_sel_o), 32'h08);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_sel",  32'(slv_sel_o), 0);
    chk("mid_rst_ack",  32'(gb_ack_o), 0);
    chk("mid_rst_ecnt", 32'(err_count_o), 0);
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acks += int'(gb_ack_o);
    end
    chk("mid_noack", 32'(acks), 0);
    xfer(1, 0, 16'h0020, 0, 8'h04, 0, lat, nrd, nwr, sel_s, wd_s);
    chk("post_lat", 32'(lat), 4);
    chk("post_dat", gb_dat_o, 32'h12345678);

    // Continuous rd+wr: DONE errors plus dropped strobes.
    gb_rd_i = 1'b1; gb_wr_i = 1'b1;
    repeat (10) @(negedge clk);
    gb_rd_i = 1'b0; gb_wr_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("drop_ecnt", 32'(err_count_o), 10);
    chk("drop_err",  32'(err_o), 1);

    gb_rd_i = 1'b1; gb_wr_i = 1'b1;
    repeat (65540) @(negedge clk);
    gb_rd_i = 1'b0; gb_wr_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_ecnt", 32'(err_count_o), 32'hFFFF);
    chk("sat_err",  32'(err_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
